// File: rtl/i2c_reg_slave_if.sv
// Host-side register port of the I2C register slave: bus-write strobes out, host read port in/out.
// Latency: oRD_DATA follows iRD_ADDR by one iCLK cycle; oWR_STB is a single-cycle pulse.
// Backpressure: none; the host must accept every oWR_STB pulse as it occurs.
interface i2c_reg_slave_if;
    logic       oWR_STB;
    logic [7:0] oWR_ADDR;
    logic [7:0] oWR_DATA;
    logic [7:0] iRD_ADDR;
    logic [7:0] oRD_DATA;
    logic       oBUSY;

    modport slave (
        output oWR_STB, oWR_ADDR, oWR_DATA, oRD_DATA, oBUSY,
        input  iRD_ADDR
    );

    modport master (
        input  oWR_STB, oWR_ADDR, oWR_DATA, oRD_DATA, oBUSY,
        output iRD_ADDR
    );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C slave fronting a 256x8 register file; bus writes via sub-address pointer, optional bus reads (macro I2C_SLAVE_READ_EN).
// Latency: bus events lag the pins by 2 sync + FILTER_LEN cycles; host read port is 1 cycle.
// Backpressure: none on the host side; the I2C bus is never clock-stretched, a non-matching address is NACKed.
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h20,
    parameter int         FILTER_LEN = 3
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            I2C_SCLK,
    inout  wire             I2C_SDAT,
    i2c_reg_slave_if.slave  regIf
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    localparam logic [2:0] FLT_LAST = 3'(FILTER_LEN - 1);

    logic [1:0] sclSync, sdaSync;
    logic [2:0] sclCnt, sdaCnt;
    logic       sclFilt, sdaFilt, sclPrev, sdaPrev;
    logic       sclRise, sclFall, startEv, stopEv, addrHit;

    state_t     state;
    logic [3:0] bitCnt;
    logic [7:0] shiftReg;
    logic [7:0] ptr;
    logic       sdaDrv;
`ifdef I2C_SLAVE_READ_EN
    logic       rwBit;
    logic       ackBit;
`endif

    logic [7:0] mem [256];

    // Open drain: only ever pull low or let go.
    assign I2C_SDAT = sdaDrv ? 1'b0 : 1'bz;

    // Synchronize both lines, then accept a new level only after FILTER_LEN equal samples.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
            sclCnt  <= '0;
            sdaCnt  <= '0;
            sclFilt <= 1'b1;
            sdaFilt <= 1'b1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclSync <= {sclSync[0], I2C_SCLK};
            sdaSync <= {sdaSync[0], I2C_SDAT};
            sclPrev <= sclFilt;
            sdaPrev <= sdaFilt;
            if (sclSync[1] == sclFilt) begin
                sclCnt <= '0;
            end else if (sclCnt == FLT_LAST) begin
                sclFilt <= sclSync[1];
                sclCnt  <= '0;
            end else begin
                sclCnt <= sclCnt + 3'd1;
            end
            if (sdaSync[1] == sdaFilt) begin
                sdaCnt <= '0;
            end else if (sdaCnt == FLT_LAST) begin
                sdaFilt <= sdaSync[1];
                sdaCnt  <= '0;
            end else begin
                sdaCnt <= sdaCnt + 3'd1;
            end
        end
    end

    assign sclRise = sclFilt & ~sclPrev;
    assign sclFall = ~sclFilt & sclPrev;
    // SDA edges only count as START/STOP when SCL was high on both samples.
    assign startEv = sclFilt & sclPrev & sdaPrev & ~sdaFilt;
    assign stopEv  = sclFilt & sclPrev & ~sdaPrev & sdaFilt;

`ifdef I2C_SLAVE_READ_EN
    assign addrHit = (shiftReg[7:1] == SLAVE_ADDR);
`else
    // Without read support a read address is treated as a miss and NACKed.
    assign addrHit = (shiftReg == {SLAVE_ADDR, 1'b0});
`endif

    // Protocol FSM: byte shifting, ACK drive, pointer handling and write strobes.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state          <= IDLE;
            bitCnt         <= '0;
            shiftReg       <= '0;
            ptr            <= '0;
            sdaDrv         <= 1'b0;
            regIf.oWR_STB  <= 1'b0;
            regIf.oWR_ADDR <= '0;
            regIf.oWR_DATA <= '0;
            regIf.oBUSY    <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            rwBit          <= 1'b0;
            ackBit         <= 1'b1;
`endif
        end else begin
            regIf.oWR_STB <= 1'b0;
            if (startEv) begin
                state  <= ADDR;
                bitCnt <= '0;
                sdaDrv <= 1'b0;
            end else if (stopEv) begin
                state       <= IDLE;
                bitCnt      <= '0;
                sdaDrv      <= 1'b0;
                regIf.oBUSY <= 1'b0;
            end else begin
                if ((state == ADDR || state == SUB || state == WDATA) && sclRise && bitCnt != 4'd8) begin
                    shiftReg <= {shiftReg[6:0], sdaFilt};
                    bitCnt   <= bitCnt + 4'd1;
                end
                case (state)
                    ADDR: if (sclFall && bitCnt == 4'd8) begin
                        bitCnt <= '0;
                        if (addrHit) begin
                            state       <= ADDR_ACK;
                            sdaDrv      <= 1'b1;
                            regIf.oBUSY <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                            rwBit       <= shiftReg[0];
`endif
                        end else begin
                            state       <= IGNORE;
                            regIf.oBUSY <= 1'b0;
                        end
                    end
                    SUB: if (sclFall && bitCnt == 4'd8) begin
                        state  <= SUB_ACK;
                        sdaDrv <= 1'b1;
                        bitCnt <= '0;
                    end
                    WDATA: if (sclFall && bitCnt == 4'd8) begin
                        state  <= WDATA_ACK;
                        sdaDrv <= 1'b1;
                        bitCnt <= '0;
                    end
                    ADDR_ACK: if (sclFall) begin
`ifdef I2C_SLAVE_READ_EN
                        if (rwBit) begin
                            state    <= RDATA;
                            shiftReg <= mem[ptr];
                            sdaDrv   <= ~mem[ptr][7];
                            ptr      <= ptr + 8'd1;
                        end else begin
                            state  <= SUB;
                            sdaDrv <= 1'b0;
                        end
`else
                        state  <= SUB;
                        sdaDrv <= 1'b0;
`endif
                    end
                    SUB_ACK: if (sclFall) begin
                        state  <= WDATA;
                        sdaDrv <= 1'b0;
                        ptr    <= shiftReg;
                    end
                    WDATA_ACK: if (sclFall) begin
                        state          <= WDATA;
                        sdaDrv         <= 1'b0;
                        regIf.oWR_STB  <= 1'b1;
                        regIf.oWR_ADDR <= ptr;
                        regIf.oWR_DATA <= shiftReg;
                        ptr            <= ptr + 8'd1;
                    end
`ifdef I2C_SLAVE_READ_EN
                    RDATA: begin
                        if (sclRise && bitCnt != 4'd8) begin
                            bitCnt <= bitCnt + 4'd1;
                        end else if (sclFall && bitCnt == 4'd8) begin
                            state  <= RACK;
                            sdaDrv <= 1'b0;
                            bitCnt <= '0;
                        end else if (sclFall && bitCnt != 4'd0) begin
                            shiftReg <= {shiftReg[6:0], 1'b0};
                            sdaDrv   <= ~shiftReg[6];
                        end
                    end
                    RACK: begin
                        if (sclRise) begin
                            ackBit <= sdaFilt;
                        end else if (sclFall) begin
                            if (!ackBit) begin
                                state    <= RDATA;
                                shiftReg <= mem[ptr];
                                sdaDrv   <= ~mem[ptr][7];
                                ptr      <= ptr + 8'd1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
`endif
                    default: sdaDrv <= 1'b0;
                endcase
            end
        end
    end

    // File write on WDATA_ACK completion; no reset so contents survive iRST_N.
    always_ff @(posedge iCLK) begin
        if (state == WDATA_ACK && sclFall) begin
            mem[ptr] <= shiftReg;
        end
    end

    // Registered host read; a same-cycle bus write to that address returns the old value.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            regIf.oRD_DATA <= '0;
        end else begin
            regIf.oRD_DATA <= mem[regIf.iRD_ADDR];
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, write-strobe scoreboard, host-port and bus checks.
// Latency: expected strobes are queued before the byte is sent and popped by a monitor on oWR_STB.
// Backpressure: not applicable; a watchdog bounds the whole run.
module tb_i2c_reg_slave;

    localparam int Q = 10;

    logic iCLK     = 1'b0;
    logic iRST_N   = 1'b0;
    logic sclLine  = 1'b1;
    logic tbSdaLow = 1'b0;
    wire  sdaBus;

    assign sdaBus = tbSdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    i2c_reg_slave_if regIf ();

    i2c_reg_slave #(.SLAVE_ADDR(7'h20), .FILTER_LEN(3)) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .I2C_SCLK (sclLine),
        .I2C_SDAT (sdaBus),
        .regIf    (regIf)
    );

    always #10 iCLK = ~iCLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t  expQ[$];
    wr_t  monE;
    int   errCnt    = 0;
    int   chkCnt    = 0;
    logic watchDrive = 1'b0;
    int   driveSeen = 0;
    int   busySeen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge iCLK) begin
        if (regIf.oWR_STB === 1'b1) begin
            if (expQ.size() == 0) begin
                chkCnt++;
                errCnt++;
                $display("FAIL unexpected_strobe: got addr %0h data %0h, want no strobe",
                         regIf.oWR_ADDR, regIf.oWR_DATA);
            end else begin
                monE = expQ.pop_front();
                check("wr_addr", 32'(regIf.oWR_ADDR), 32'(monE.a));
                check("wr_data", 32'(regIf.oWR_DATA), 32'(monE.d));
            end
        end
    end

    // Watch for the DUT pulling SDA or raising oBUSY while it should stay silent.
    always @(negedge iCLK) begin
        if (watchDrive) begin
            if (!tbSdaLow && sdaBus === 1'b0) driveSeen++;
            if (regIf.oBUSY !== 1'b0)         busySeen++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, want run completion");
        $fatal(1, "watchdog");
    end

    task automatic waitQ();
        repeat (Q) @(negedge iCLK);
    endtask

    task automatic i2cStart();
        if (sclLine == 1'b0) begin
            tbSdaLow = 1'b0; waitQ();
            sclLine  = 1'b1; waitQ();
        end
        tbSdaLow = 1'b1; waitQ();
        sclLine  = 1'b0; waitQ();
    endtask

    task automatic i2cStop();
        tbSdaLow = 1'b1; waitQ();
        sclLine  = 1'b1; waitQ();
        tbSdaLow = 1'b0; waitQ();
        waitQ();
    endtask

    task automatic sendBit(input logic b);
        tbSdaLow = ~b; waitQ();
        sclLine  = 1'b1; waitQ(); waitQ();
        sclLine  = 1'b0; waitQ();
    endtask

    task automatic recvBit(output logic b);
        tbSdaLow = 1'b0; waitQ();
        sclLine  = 1'b1; waitQ();
        b = sdaBus;      waitQ();
        sclLine  = 1'b0; waitQ();
    endtask

    task automatic writeByte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
        recvBit(ack);
    endtask

    task automatic readByte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recvBit(b);
            v[i] = b;
        end
        sendBit(nack);
    endtask

    task automatic hostRead(input logic [7:0] a, input logic [7:0] exp, input string name);
        regIf.iRD_ADDR = a;
        repeat (2) @(negedge iCLK);
        check(name, 32'(regIf.oRD_DATA), 32'(exp));
    endtask

    logic       ack;
    logic [7:0] rb;
    logic [7:0] glitchSub;

    initial begin
        regIf.iRD_ADDR = 8'h00;
        glitchSub      = 8'h10;

        // Reset state
        repeat (3) @(negedge iCLK);
        check("rst_wr_stb",  32'(regIf.oWR_STB),  32'h0);
        check("rst_wr_addr", 32'(regIf.oWR_ADDR), 32'h0);
        check("rst_wr_data", 32'(regIf.oWR_DATA), 32'h0);
        check("rst_busy",    32'(regIf.oBUSY),    32'h0);
        check("rst_rd_data", 32'(regIf.oRD_DATA), 32'h0);
        check("rst_sda",     32'(sdaBus),         32'h1);
        iRST_N = 1'b1;
        waitQ();

        // Basic write C3 <= 01
        i2cStart();
        writeByte(8'h40, ack); check("t1_addr_ack", 32'(ack), 32'h0);
        check("t1_busy_hi", 32'(regIf.oBUSY), 32'h1);
        writeByte(8'hC3, ack); check("t1_sub_ack", 32'(ack), 32'h0);
        expQ.push_back('{a: 8'hC3, d: 8'h01});
        writeByte(8'h01, ack); check("t1_data_ack", 32'(ack), 32'h0);
        i2cStop();
        check("t1_busy_lo", 32'(regIf.oBUSY), 32'h0);
        hostRead(8'hC3, 8'h01, "t1_rd_c3");

        // Foreign address: NACK, SDA untouched, oBUSY low
        driveSeen  = 0;
        busySeen   = 0;
        watchDrive = 1'b1;
        i2cStart();
        writeByte(8'h34, ack); check("t2_addr_nack", 32'(ack), 32'h1);
        writeByte(8'h00, ack); check("t2_b1_nack",   32'(ack), 32'h1);
        writeByte(8'h00, ack); check("t2_b2_nack",   32'(ack), 32'h1);
        i2cStop();
        watchDrive = 1'b0;
        check("t2_sda_driven", 32'(driveSeen), 32'h0);
        check("t2_busy_seen",  32'(busySeen),  32'h0);

        // Pointer wrap FF -> 00
        i2cStart();
        writeByte(8'h40, ack); check("t3_addr_ack", 32'(ack), 32'h0);
        writeByte(8'hFF, ack); check("t3_sub_ack",  32'(ack), 32'h0);
        expQ.push_back('{a: 8'hFF, d: 8'hAA});
        writeByte(8'hAA, ack); check("t3_d0_ack",   32'(ack), 32'h0);
        expQ.push_back('{a: 8'h00, d: 8'h55});
        writeByte(8'h55, ack); check("t3_d1_ack",   32'(ack), 32'h0);
        i2cStop();
        hostRead(8'hFF, 8'hAA, "t3_rd_ff");
        hostRead(8'h00, 8'h55, "t3_rd_00");

        // Seed 0A/0B, then a combined write-pointer / repeated-START read
        i2cStart();
        writeByte(8'h40, ack); check("t4_addr_ack", 32'(ack), 32'h0);
        writeByte(8'h0A, ack); check("t4_sub_ack",  32'(ack), 32'h0);
        expQ.push_back('{a: 8'h0A, d: 8'h18});
        writeByte(8'h18, ack);
        expQ.push_back('{a: 8'h0B, d: 8'h5C});
        writeByte(8'h5C, ack);
        i2cStop();
        i2cStart();
        writeByte(8'h40, ack);
        writeByte(8'h0A, ack); check("t4_ptr_ack", 32'(ack), 32'h0);
        i2cStart();
        writeByte(8'h41, ack);
`ifdef I2C_SLAVE_READ_EN
        check("t4_rd_addr_ack", 32'(ack), 32'h0);
        readByte(rb, 1'b0); check("t4_rd_byte0", 32'(rb), 32'h18);
        readByte(rb, 1'b1); check("t4_rd_byte1", 32'(rb), 32'h5C);
`else
        check("t4_rd_addr_nack", 32'(ack), 32'h1);
`endif
        i2cStop();
        check("t4_busy_lo", 32'(regIf.oBUSY), 32'h0);

        // STOP four bits into a data byte: no strobe, back to IDLE
        i2cStart();
        writeByte(8'h40, ack);
        writeByte(8'h20, ack); check("t5_sub_ack", 32'(ack), 32'h0);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        i2cStop();
        check("t5_state_idle", 32'(dut.state), 32'h0);
        check("t5_busy_lo",    32'(regIf.oBUSY), 32'h0);
        check("t5_no_pending", 32'(expQ.size()), 32'h0);

        // Two-cycle SCL glitch inside the sub-address byte must not count as a bit
        i2cStart();
        writeByte(8'h40, ack);
        for (int i = 7; i >= 4; i--) sendBit(glitchSub[i]);
        @(negedge iCLK); sclLine = 1'b1;
        repeat (2) @(negedge iCLK); sclLine = 1'b0;
        waitQ();
        for (int i = 3; i >= 0; i--) sendBit(glitchSub[i]);
        recvBit(ack); check("t6_sub_ack", 32'(ack), 32'h0);
        expQ.push_back('{a: 8'h10, d: 8'h77});
        writeByte(8'h77, ack); check("t6_data_ack", 32'(ack), 32'h0);
        i2cStop();
        hostRead(8'h10, 8'h77, "t6_rd_10");

        // Reset pulse while acknowledging the sub-address
        i2cStart();
        writeByte(8'h40, ack);
        for (int i = 7; i >= 0; i--) sendBit(1'(8'h33 >> i));
        tbSdaLow = 1'b0; waitQ();
        check("t7_ack_driven", 32'(sdaBus), 32'h0);
        @(negedge iCLK); iRST_N = 1'b0;
        #1;
        check("t7_sda_released", 32'(sdaBus), 32'h1);
        repeat (2) @(negedge iCLK); iRST_N = 1'b1;
        sclLine = 1'b1; waitQ(); waitQ();
        sclLine = 1'b0; waitQ();
        i2cStop();
        i2cStart();
        writeByte(8'h40, ack); check("t7_addr_ack", 32'(ack), 32'h0);
        writeByte(8'h50, ack); check("t7_sub_ack",  32'(ack), 32'h0);
        expQ.push_back('{a: 8'h50, d: 8'h66});
        writeByte(8'h66, ack); check("t7_data_ack", 32'(ack), 32'h0);
        i2cStop();
        hostRead(8'h50, 8'h66, "t7_rd_50");

        repeat (4) @(negedge iCLK);
        check("strobes_all_seen", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
